seq_divider: RTL

//   Sequential restoring divider; inverse of the shift-add multiplier.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 42 ++++
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 101 ++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default operand width and
// the FSM state encoding (kept identical to the shift-add multiplier so both
// units decode the same debug state values).
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WORK = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
//   dividend_in  [2W-1:0]  dividend, sampled on an accepted start
//   divisor_in   [W-1:0]   divisor, sampled on an accepted start
//   start_in               request
//   busy_out               high whenever the divider is not idle
//   done_out               one-cycle pulse, results valid
//   quot_out     [2W-1:0]  quotient, held until the next completion
//   rem_out      [W-1:0]   remainder, held until the next completion
//   div_zero_out           divisor was zero, held with the results
//   state_out    [1:0]     FSM state, for observation only
//
// Handshake: start_in acts as valid and !busy_out as ready. A request is
// taken on a rising clock edge where start_in=1 and busy_out=0; start_in
// while busy_out=1 is dropped, not queued. Each accepted request produces
// exactly one done_out pulse unless reset intervenes.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [2*WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0]   divisor_in;
  logic               start_in;
  logic               busy_out;
  logic               done_out;
  logic [2*WIDTH-1:0] quot_out;
  logic [WIDTH-1:0]   rem_out;
  logic               div_zero_out;
  state_t             state_out;

  modport master (
    output dividend_in, divisor_in, start_in,
    input  busy_out, done_out, quot_out, rem_out, div_zero_out, state_out
  );

  modport slave (
    input  dividend_in, divisor_in, start_in,
    output busy_out, done_out, quot_out, rem_out, div_zero_out, state_out
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step (combinational).
//   i_r       [W-1:0]  current partial remainder (always < divisor)
//   i_d_msb            next dividend bit brought down
//   i_divisor [W-1:0]  divisor (non-zero while stepping)
//   o_r_next  [W-1:0]  partial remainder after this step
//   o_q_bit            quotient bit produced by this step
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_d_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_t;

  assign w_t     = {i_r, i_d_msb};
  assign o_q_bit = (w_t >= {1'b0, i_divisor});
  // Since i_r < divisor, t - divisor < divisor, so the low WIDTH bits of the
  // difference are the whole result.
  assign o_r_next = o_q_bit ? (w_t[WIDTH-1:0] - i_divisor) : w_t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per clock, 2W-bit quotient and W-bit remainder.
//   clk_in   clock, rising edge
//   rst_in   asynchronous active-high reset
//   bus      seq_divider_if.slave (request, status and results)
// Sequence: IDLE -> WORK (2W steps) -> WAIT (done pulse) -> IDLE, or
// IDLE -> WAIT directly when the divisor is zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk_in,
  input logic          rst_in,
  seq_divider_if.slave bus
);

  localparam int DW    = 2 * WIDTH;
  localparam int CTR_W = $clog2(DW) + 1;
  localparam logic [CTR_W-1:0] LAST_STEP = CTR_W'(DW - 1);

  state_t           r_state;
  logic [CTR_W-1:0] r_ctr;
  logic [WIDTH-1:0] r_part;     // partial remainder
  logic [DW-1:0]    r_dvd;      // dividend shifting out at MSB, quotient in at LSB
  logic [WIDTH-1:0] r_divisor;
  logic             r_done;
  logic [DW-1:0]    r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_r       (r_part),
    .i_d_msb   (r_dvd[DW-1]),
    .i_divisor (r_divisor),
    .o_r_next  (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_ctr     <= '0;
      r_part    <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_in) begin
            r_dvd     <= bus.dividend_in;
            r_divisor <= bus.divisor_in;
            r_part    <= '0;
            r_ctr     <= '0;
            if (bus.divisor_in == '0) begin
              r_quot  <= '1;
              r_rem   <= bus.dividend_in[WIDTH-1:0];
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_WORK;
            end
          end
        end
        ST_WORK: begin
          // The dividend bit consumed at the MSB frees a slot at the LSB for
          // the new quotient bit, so one register carries both.
          r_part <= w_r_next;
          r_dvd  <= {r_dvd[DW-2:0], w_q_bit};
          r_ctr  <= r_ctr + CTR_W'(1);
          if (r_ctr == LAST_STEP) begin
            r_quot  <= {r_dvd[DW-2:0], w_q_bit};
            r_rem   <= w_r_next;
            r_dz    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_out     = (r_state != ST_IDLE);
  assign bus.done_out     = r_done;
  assign bus.quot_out     = r_quot;
  assign bus.rem_out      = r_rem;
  assign bus.div_zero_out = r_dz;
  assign bus.state_out    = r_state;

endmodule
